// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined RV32 core.
// Owns the architectural PC, issues instruction-memory requests and loads the
// IF/ID pipeline register. It honours hazard-unit stalls and flushes IF/ID with
// a NOP on a taken redirect from EX.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a target that is not word aligned sets the sticky
//               fetch_misalign flag and parks the stage in S_TRAP until rst.
//   undefined : the redirect target is word aligned by clearing bits [1:0],
//               and fetching continues normally.
//
// imem_req, imem_addr and pc_out are taken straight from registers, so none
// of them has a combinational path from pcsrc or stall_if.

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        pcsrc,
  input  logic        stall_if,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  // Fetch sequencing states. S_TRAP exists only when the misalign trap is built.
  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    S_TRAP  = 2'd3
`endif
  } fetch_state_e;

  fetch_state_e state_q;

  // Architectural PC and IF/ID pipeline register.
  logic [31:0] pc_q;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_pc_plus4_q;
  logic [31:0] if_id_instr_q;
  logic        if_id_valid_q;

  // Word captured while the hazard unit stalls; replayed into IF/ID once the
  // stall clears so the same address is never fetched twice.
  logic [31:0] hold_q;

  // Registered request strobe: high exactly while the FSM sits in S_FETCH.
  logic        req_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic        misalign_s;
`endif

  // Next-state helpers.
  logic [31:0] pc_plus4_d;
  logic [31:0] redirect_pc_d;
  logic [31:0] redirect_pc_plus4_d;
  logic        redirect_s;

  // Sequential PC increment and redirect target selection.
  always_comb begin
    pc_plus4_d          = pc_q + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
    // The PC takes the target unmodified; a misaligned target traps instead.
    redirect_pc_d       = pc_next;
    misalign_s          = (pc_next[1:0] != 2'b00);
`else
    // Without the trap, force the fetch address onto a word boundary.
    redirect_pc_d       = {pc_next[31:2], 2'b00};
`endif
    redirect_pc_plus4_d = pc_next + 32'd4;
  end

  // A redirect is honoured in every state except the trap state.
  always_comb begin
    redirect_s = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (pcsrc && (state_q != S_TRAP)) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
`else
    if (pcsrc) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
`endif
  end

  // Fetch FSM: PC, IF/ID, hold register and request strobe, with the
  // priority rst > redirect > stall > normal fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_RST;
      pc_q             <= RESET_PC;
      if_id_pc_q       <= RESET_PC;
      if_id_pc_plus4_q <= RESET_PC + 32'd4;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      hold_q           <= NOP_INSTR;
      req_q            <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q       <= 1'b0;
`endif
    end else if (redirect_s) begin
      // Flush IF/ID, drop any held word and ignore a same-cycle ack.
      pc_q             <= redirect_pc_d;
      if_id_pc_q       <= pc_next;
      if_id_pc_plus4_q <= redirect_pc_plus4_d;
      if_id_instr_q    <= NOP_INSTR;
      if_id_valid_q    <= 1'b0;
      hold_q           <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign_s) begin
        misalign_q <= 1'b1;
        state_q    <= S_TRAP;
        req_q      <= 1'b0;
      end else begin
        state_q    <= S_FETCH;
        req_q      <= 1'b1;
      end
`else
      state_q          <= S_FETCH;
      req_q            <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_RST: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack && stall_if) begin
            // Park the returned word; IF/ID and PC stay put while stalled.
            hold_q  <= imem_rdata;
            state_q <= S_HOLD;
            req_q   <= 1'b0;
          end else if (imem_ack) begin
            if_id_pc_q       <= pc_q;
            if_id_pc_plus4_q <= pc_plus4_d;
            if_id_instr_q    <= imem_rdata;
            if_id_valid_q    <= 1'b1;
            pc_q             <= pc_plus4_d;
          end else begin
            // Waiting on imem: keep the request up at the same address.
            req_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall_if) begin
            // Replay the parked word; PC still points at it.
            if_id_pc_q       <= pc_q;
            if_id_pc_plus4_q <= pc_plus4_d;
            if_id_instr_q    <= hold_q;
            if_id_valid_q    <= 1'b1;
            pc_q             <= pc_plus4_d;
            state_q          <= S_FETCH;
            req_q            <= 1'b1;
          end else begin
            req_q <= 1'b0;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP: begin
          // Only rst leaves the trap; no further requests are issued.
          req_q <= 1'b0;
        end
`endif
        default: begin
          state_q <= S_RST;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are straight register taps.
  assign imem_addr      = pc_q;
  assign imem_req       = req_q;
  assign pc_out         = pc_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc_plus4_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_valid    = if_id_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misalign = misalign_q;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32 core: owns the architectural PC register, issues requests to instruction memory, and loads the IF/ID pipeline register. It consumes the redirect pair (`pc_next`, `pcsrc`) produced by the branch/jump next-PC logic in EX. It also honours load-use stalls from the hazard unit, and on a taken redirect it flushes the instruction in IF/ID with a NOP.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, instruction word (`addi x0,x0,0`) inserted on flush and reset

- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous to `clk`, active-high
- `pc_next`  in  32  redirect target from the next-PC logic
- `pcsrc`  in  1  redirect taken (branch taken, JAL, JALR)
- `stall_if`  in  1  hazard-unit stall; holds PC and IF/ID
- `imem_addr`  out  32  fetch address; always equals `pc_out`
- `imem_req`  out  1  fetch request
- `imem_ack`  in  1  data valid on `imem_rdata` this cycle; may assert in the same cycle as `imem_req`
- `imem_rdata`  in  32  instruction word
- `pc_out`  out  32  current PC register
- `if_id_pc`  out  32  PC of the instruction in IF/ID
- `if_id_pc_plus4`  out  32  `if_id_pc` + 4
- `if_id_instr`  out  32  instruction in IF/ID
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `fetch_misalign`  out  1  sticky misaligned-target flag; present only with `FETCH_MISALIGN_TRAP_EN`

## Operation
- The FSM has four states:
  - `S_RST`: entered on reset; `imem_req`=0. Moves unconditionally to `S_FETCH`.
  - `S_FETCH`: `imem_req`=1 and `imem_addr`=`pc_out`.
    - `imem_ack`=1, `stall_if`=0: load IF/ID with {`pc_out`, `imem_rdata`}, set `if_id_valid`=1, PC <= PC+4. Stay in `S_FETCH`.
    - `imem_ack`=1, `stall_if`=1: capture `imem_rdata` in the internal hold register. IF/ID is unchanged. Go to `S_HOLD`.
    - `imem_ack`=0: no state change.
  - `S_HOLD`: `imem_req`=0. When `stall_if`=0: load IF/ID from the hold register, PC <= PC+4, go to `S_FETCH`.
  - `S_TRAP`: exists only with `FETCH_MISALIGN_TRAP_EN`. `imem_req`=0. Exited only by `rst`.
- Redirect priority: `rst` > `pcsrc` > `stall_if` > normal fetch.
- On `pcsrc`=1 in any non-trap state:
  - PC <= `pc_next`.
  - IF/ID <= {`if_id_pc`=`pc_next`, `if_id_instr`=`NOP_INSTR`, `if_id_valid`=0}.
  - The hold register is discarded and the FSM goes to `S_FETCH`.
  - A same-cycle `imem_ack` is ignored.
  - `pcsrc` overrides `stall_if`.
- The imem request is abortable: deasserting `imem_req` or changing `imem_addr` cancels the outstanding request, and imem must not ack stale addresses.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- While `stall_if`=1 with no redirect, all IF/ID outputs and `pc_out` hold their values.

## Timing
- Reset values:
  - `pc_out`=`RESET_PC`
  - `if_id_pc`=`RESET_PC`
  - `if_id_pc_plus4`=`RESET_PC`+4
  - `if_id_instr`=`NOP_INSTR`
  - `if_id_valid`=0
  - `imem_req`=0
  - `fetch_misalign`=0
- The first `imem_req` asserts in the second cycle after `rst` deasserts (one cycle in `S_RST`).
- With zero-wait imem (ack in the same cycle as req), throughput is one instruction per cycle. IF/ID updates on the edge that ends the ack cycle.
- Redirect latency: the edge that samples `pcsrc`=1 loads the PC. The fetch of `pc_next` is requested in the following cycle.
- Leaving `S_HOLD` takes one cycle after `stall_if` falls. No re-fetch occurs, because the data comes from the hold register.
- `imem_addr`, `imem_req` and `pc_out` are registered-state decodes and have no combinational path from `pcsrc` or `stall_if`.
- Reset mid-fetch abandons the request immediately: `imem_req`=0 in the cycle after the reset edge.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `pc_next[1:0]`≠0 sets `fetch_misalign`=1 (sticky) and loads the PC unmodified.
  - IF/ID is flushed and the FSM enters `S_TRAP`; no further requests are issued until `rst`.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - The port is absent.
  - The PC loads {`pc_next[31:2]`, 2'b00} and fetching continues normally.

## Test plan
- Reset, zero-wait imem returning addr^32'hA5A5_0000 → the first req is at 0x0. IF/ID shows pc 0x0, 0x4, 0x8 on consecutive cycles with `if_id_valid`=1.
- Ack at pc 0x8 with `stall_if`=1 for 3 cycles → IF/ID stays at pc 0x4 and `imem_req`=0 in `S_HOLD`. The cycle after the stall drops, IF/ID = pc 0x8 with no new request to 0x8.
- `pcsrc`=1, `pc_next`=0x100 together with ack and stall → the next cycle has `if_id_valid`=0, `if_id_instr`=0x13 and `imem_addr`=0x100, and the acked word is dropped.
- Imem with a 2-cycle ack latency, `pcsrc` to 0x40 on the first wait cycle → the request switches to 0x40, and the instruction from the old address never appears in IF/ID.
- PC=0xFFFF_FFFC fetch → next `pc_out`=0x0 and `if_id_pc_plus4`=0x0.
- `pc_next`=0x102 with `pcsrc`:
  - Macro on: `fetch_misalign`=1 and `imem_req` stays 0 until `rst`.
  - Macro off: `imem_addr`=0x100.
